serial_magnitude_comparator: RTL and testbench
==============================================

# serial_magnitude_comparator

Parametrised, multi-cycle magnitude comparator that compares two WIDTH-bit operands MSB-first, BITS_PER_CYCLE bits per clock, with early termination on the first differing chunk. It supports unsigned and two's-complement signed modes and uses a start/done handshake. It replaces fixed-width combinational comparator chains where operand width is large or timing is tight, and produces the same less/equal/greater flag triple.

## Interface

- WIDTH, 8, operand width in bits; must be a positive multiple of BITS_PER_CYCLE.
- BITS_PER_CYCLE, 1, bits examined per SCAN cycle; chunk count C = WIDTH/BITS_PER_CYCLE.

- clk  in  1  single clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request a comparison; accepted only when busy=0.
- signed_mode  in  1  1 = two's-complement compare, 0 = unsigned; sampled with start.
- x  in  WIDTH  operand A; sampled on the accepting edge.
- y  in  WIDTH  operand B; sampled on the accepting edge.
- busy  out  1  high while a comparison is in progress.
- done  out  1  one-cycle pulse: result just became valid.
- l_out  out  1  x < y.
- e_out  out  1  x == y.
- g_out  out  1  x > y.

## Operation

- FSM states: IDLE, SCAN. DONE is not a separate state; done is a registered pulse.
- IDLE: busy=0. On start=1, latch x, y and signed_mode, set chunk index k=0, go to SCAN.
- SCAN: busy=1. Compare chunk k, meaning bits [WIDTH-1-k*B -: B] with B=BITS_PER_CYCLE, of the latched operands as an unsigned B-bit value.
- Signed mode: in chunk 0 only, invert the MSB of both x and y before comparing. This makes the result exact two's-complement ordering. Other chunks are unchanged.
- If chunk k differs: set l_out/g_out accordingly, e_out=0, done=1, and return to IDLE.
- If chunk k is equal and k=C-1: set e_out=1, l_out=g_out=0, done=1, and return to IDLE.
- Otherwise increment k and stay in SCAN.
- Exactly one of l_out/e_out/g_out is 1 at all times.
- Outputs hold their last result until the next completion. They do not change on start.
- start while busy=1 is ignored; there is no queueing.
- Input changes on x/y/signed_mode after the accepting edge have no effect.
- The chunk index counter is $clog2(C) bits wide, minimum 1. It never wraps, because SCAN exits at k=C-1.

## Timing

- Reset values: state=IDLE, busy=0, done=0, l_out=0, e_out=1, g_out=0, k=0. Reset overrides start in the same cycle.
- Reset during SCAN aborts the comparison. The next edge produces the reset values, and no done pulse is issued.
- Let start be accepted at edge E0. busy=1 from E0.
- With deciding chunk d (the first differing chunk, or C-1 if all are equal): at edge E(d+1), the result registers update, done=1, and busy=0. done drops at E(d+2) unless a new completion occurs.
- Latency: best case 1 cycle, worst case C cycles (equal operands, or a difference only in the last chunk).
- Back-to-back: start=1 in the cycle where done=1 is accepted, because busy=0. Throughput is one comparison per d+1 cycles.

## Test plan

- WIDTH=8, B=1, unsigned: x=0xA5, y=0xA5 -> busy high for 8 cycles; done at E8 with e=1, l=0, g=0.
- WIDTH=8, B=1: x=0x80, y=0x7F with signed_mode=0 -> done at E1 with g=1. Repeat with signed_mode=1 -> done at E1 with l=1.
- WIDTH=8, B=1, unsigned: x=0x12, y=0x13 -> done at E8 with l=1. Pulse start at cycles E2–E7 -> ignored, result unchanged.
- WIDTH=8, B=4, signed: x=0xFE (-2), y=0x01 -> done at E1 with l=1. Then x=0x3C, y=0x3D -> done at E2 with l=1.
- Reset mid-op: x=0x00, y=0x01, B=1, reset asserted at E4 -> at E5 busy=0, done=0, e=1, and no done pulse ever appears for that request.
- Back-to-back: assert start with x=0x05, y=0x03 in the done cycle of a prior compare -> accepted; done at E6 relative to the new start with g=1.

Source files
------------

// File: rtl/serial_magnitude_comparator.sv
// Multi-cycle MSB-first magnitude comparator: BITS_PER_CYCLE bits per clock,
// early exit on the first differing chunk, unsigned or two's-complement ordering.
//
// state | meaning
// IDLE  | waiting for start; result flags hold the last completed comparison
// SCAN  | comparing one chunk per cycle, most significant chunk first
module serial_magnitude_comparator #(
    parameter int WIDTH          = 8,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic             signed_mode_i,
    input  logic [WIDTH-1:0] x_i,
    input  logic [WIDTH-1:0] y_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             l_out_o,
    output logic             e_out_o,
    output logic             g_out_o
);

    localparam int CHUNKS = WIDTH / BITS_PER_CYCLE;
    localparam int KW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(CHUNKS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t                    state_q, state_d;
    logic [KW-1:0]             k_q, k_d;
    logic [WIDTH-1:0]          x_q, x_d;
    logic [WIDTH-1:0]          y_q, y_d;
    logic                      signed_q, signed_d;
    logic                      done_q, done_d;
    logic                      l_q, l_d;
    logic                      e_q, e_d;
    logic                      g_q, g_d;

    logic [BITS_PER_CYCLE-1:0] chunk_x;
    logic [BITS_PER_CYCLE-1:0] chunk_y;
    logic                      flip_msb;

    // Operands shift left after each equal chunk, so the current chunk is
    // always the top B bits; flipping the sign bit in chunk 0 turns a
    // two's-complement compare into an unsigned one.
    always_comb begin
        flip_msb = signed_q && (k_q == '0);
        chunk_x  = x_q[WIDTH-1 -: BITS_PER_CYCLE];
        chunk_y  = y_q[WIDTH-1 -: BITS_PER_CYCLE];
        chunk_x[BITS_PER_CYCLE-1] = chunk_x[BITS_PER_CYCLE-1] ^ flip_msb;
        chunk_y[BITS_PER_CYCLE-1] = chunk_y[BITS_PER_CYCLE-1] ^ flip_msb;
    end

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        x_d      = x_q;
        y_d      = y_q;
        signed_d = signed_q;
        done_d   = 1'b0;
        l_d      = l_q;
        e_d      = e_q;
        g_d      = g_q;

        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    x_d      = x_i;
                    y_d      = y_i;
                    signed_d = signed_mode_i;
                    k_d      = '0;
                    state_d  = SCAN;
                end
            end
            SCAN: begin
                if (chunk_x != chunk_y) begin
                    l_d     = (chunk_x < chunk_y);
                    g_d     = (chunk_x > chunk_y);
                    e_d     = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (k_q == K_LAST) begin
                    l_d     = 1'b0;
                    g_d     = 1'b0;
                    e_d     = 1'b1;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    k_d = k_q + 1'b1;
                    x_d = x_q << BITS_PER_CYCLE;
                    y_d = y_q << BITS_PER_CYCLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= IDLE;
            k_q      <= '0;
            x_q      <= '0;
            y_q      <= '0;
            signed_q <= 1'b0;
            done_q   <= 1'b0;
            l_q      <= 1'b0;
            e_q      <= 1'b1;
            g_q      <= 1'b0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            x_q      <= x_d;
            y_q      <= y_d;
            signed_q <= signed_d;
            done_q   <= done_d;
            l_q      <= l_d;
            e_q      <= e_d;
            g_q      <= g_d;
        end
    end

    assign busy_o  = (state_q == SCAN);
    assign done_o  = done_q;
    assign l_out_o = l_q;
    assign e_out_o = e_q;
    assign g_out_o = g_q;

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Directed bench for serial_magnitude_comparator: one 8-bit/1-bit-per-cycle
// instance and one 8-bit/4-bit-per-cycle instance sharing clock and reset.
module tb_serial_magnitude_comparator;

    logic       clk = 1'b0;
    logic       reset;
    logic       start1, sm1, start4, sm4;
    logic [7:0] x1, y1, x4, y4;
    logic       busy1, done1, l1, e1, g1;
    logic       busy4, done4, l4, e4, g4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_magnitude_comparator #(.WIDTH(8), .BITS_PER_CYCLE(1)) u_b1 (
        .clk_i(clk), .reset_i(reset), .start_i(start1), .signed_mode_i(sm1),
        .x_i(x1), .y_i(y1), .busy_o(busy1), .done_o(done1),
        .l_out_o(l1), .e_out_o(e1), .g_out_o(g1)
    );

    serial_magnitude_comparator #(.WIDTH(8), .BITS_PER_CYCLE(4)) u_b4 (
        .clk_i(clk), .reset_i(reset), .start_i(start4), .signed_mode_i(sm4),
        .x_i(x4), .y_i(y4), .busy_o(busy4), .done_o(done4),
        .l_out_o(l4), .e_out_o(e4), .g_out_o(g4)
    );

    // Presents operands with start=1 so the next edge (E0) accepts them.
    task automatic launch(input bit wide, input logic [7:0] a, input logic [7:0] b,
                          input logic sm);
        if (wide) begin x4 = a; y4 = b; sm4 = sm; start4 = 1'b1; end
        else      begin x1 = a; y1 = b; sm1 = sm; start1 = 1'b1; end
        @(posedge clk); #1;
        start1 = 1'b0;
        start4 = 1'b0;
    endtask

    // Returns the edge index (relative to E0) at which done was seen, or -1.
    task automatic wait_done(input bit wide, input int budget, output int lat);
        lat = -1;
        for (int i = 1; i <= budget; i++) begin
            @(posedge clk); #1;
            if ((wide ? done4 : done1) === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        start1 = 1'b1; start4 = 1'b1;
        x1 = 8'h00; y1 = 8'h01; sm1 = 1'b0;
        x4 = 8'h00; y4 = 8'h01; sm4 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL reset_busy1 got=%b exp=0", busy1); end
        checks++; if (done1 !== 1'b0) begin errors++; $display("FAIL reset_done1 got=%b exp=0", done1); end
        checks++; if ({l1, e1, g1} !== 3'b010) begin errors++; $display("FAIL reset_flags1 got=%b exp=010", {l1, e1, g1}); end
        checks++; if (busy4 !== 1'b0) begin errors++; $display("FAIL reset_busy4 got=%b exp=0", busy4); end
        checks++; if ({l4, e4, g4} !== 3'b010) begin errors++; $display("FAIL reset_flags4 got=%b exp=010", {l4, e4, g4}); end
        start1 = 1'b0; start4 = 1'b0;
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_equal;
        int busy_cycles;
        busy_cycles = 0;
        launch(1'b0, 8'hA5, 8'hA5, 1'b0);
        for (int i = 1; i <= 12; i++) begin
            if (busy1 === 1'b1) busy_cycles++;
            @(posedge clk); #1;
            if (done1 === 1'b1) begin
                checks++; if (i != 8) begin errors++; $display("FAIL equal_latency got=%0d exp=8", i); end
                break;
            end
            if (i == 12) begin
                checks++; errors++; $display("FAIL equal_timeout got=no_done exp=done_at_8");
            end
        end
        checks++; if (busy_cycles != 8) begin errors++; $display("FAIL equal_busy_cycles got=%0d exp=8", busy_cycles); end
        checks++; if ({l1, e1, g1} !== 3'b010) begin errors++; $display("FAIL equal_flags got=%b exp=010", {l1, e1, g1}); end
        checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL equal_busy_at_done got=%b exp=0", busy1); end
        @(posedge clk); #1;
        checks++; if (done1 !== 1'b0) begin errors++; $display("FAIL equal_done_pulse got=%b exp=0", done1); end
        checks++; if (e1 !== 1'b1) begin errors++; $display("FAIL equal_hold got=%b exp=1", e1); end
    endtask

    task automatic test_signed;
        int lat;
        launch(1'b0, 8'h80, 8'h7F, 1'b0);
        wait_done(1'b0, 12, lat);
        checks++; if (lat != 1) begin errors++; $display("FAIL unsigned_80_7f_latency got=%0d exp=1", lat); end
        checks++; if ({l1, e1, g1} !== 3'b001) begin errors++; $display("FAIL unsigned_80_7f_flags got=%b exp=001", {l1, e1, g1}); end
        @(posedge clk); #1;
        launch(1'b0, 8'h80, 8'h7F, 1'b1);
        wait_done(1'b0, 12, lat);
        checks++; if (lat != 1) begin errors++; $display("FAIL signed_80_7f_latency got=%0d exp=1", lat); end
        checks++; if ({l1, e1, g1} !== 3'b100) begin errors++; $display("FAIL signed_80_7f_flags got=%b exp=100", {l1, e1, g1}); end
        @(posedge clk); #1;
    endtask

    task automatic test_ignore_start;
        // Previous result is l=1 (signed 0x80 < 0x7F); change the flags first.
        int lat;
        launch(1'b0, 8'h7F, 8'h7F, 1'b0);
        wait_done(1'b0, 12, lat);
        checks++; if (e1 !== 1'b1) begin errors++; $display("FAIL ignore_pre_equal got=%b exp=1", e1); end
        @(posedge clk); #1;
        launch(1'b0, 8'h12, 8'h13, 1'b0);
        x1 = 8'hFF; y1 = 8'h00; sm1 = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            start1 = (i >= 2 && i <= 7);
            @(posedge clk); #1;
            checks++; if (done1 !== (i == 8)) begin errors++; $display("FAIL ignore_done_e%0d got=%b exp=%b", i, done1, (i == 8)); end
            if (i == 4) begin
                checks++; if ({l1, e1, g1} !== 3'b010) begin errors++; $display("FAIL ignore_hold_mid got=%b exp=010", {l1, e1, g1}); end
            end
        end
        start1 = 1'b0;
        checks++; if ({l1, e1, g1} !== 3'b100) begin errors++; $display("FAIL ignore_flags got=%b exp=100", {l1, e1, g1}); end
        @(posedge clk); #1;
        checks++; if ({busy1, done1} !== 2'b00) begin errors++; $display("FAIL ignore_no_restart got=%b exp=00", {busy1, done1}); end
    endtask

    task automatic test_chunk4;
        int lat;
        launch(1'b1, 8'hFE, 8'h01, 1'b1);
        checks++; if (busy4 !== 1'b1) begin errors++; $display("FAIL b4_busy got=%b exp=1", busy4); end
        wait_done(1'b1, 6, lat);
        checks++; if (lat != 1) begin errors++; $display("FAIL b4_fe_01_latency got=%0d exp=1", lat); end
        checks++; if ({l4, e4, g4} !== 3'b100) begin errors++; $display("FAIL b4_fe_01_flags got=%b exp=100", {l4, e4, g4}); end
        launch(1'b1, 8'h3C, 8'h3D, 1'b1);
        wait_done(1'b1, 6, lat);
        checks++; if (lat != 2) begin errors++; $display("FAIL b4_3c_3d_latency got=%0d exp=2", lat); end
        checks++; if ({l4, e4, g4} !== 3'b100) begin errors++; $display("FAIL b4_3c_3d_flags got=%b exp=100", {l4, e4, g4}); end
        launch(1'b1, 8'hFE, 8'h01, 1'b0);
        wait_done(1'b1, 6, lat);
        checks++; if (lat != 1) begin errors++; $display("FAIL b4_unsigned_latency got=%0d exp=1", lat); end
        checks++; if ({l4, e4, g4} !== 3'b001) begin errors++; $display("FAIL b4_unsigned_flags got=%b exp=001", {l4, e4, g4}); end
        launch(1'b1, 8'h5A, 8'h5A, 1'b1);
        wait_done(1'b1, 6, lat);
        checks++; if (lat != 2) begin errors++; $display("FAIL b4_equal_latency got=%0d exp=2", lat); end
        checks++; if ({l4, e4, g4} !== 3'b010) begin errors++; $display("FAIL b4_equal_flags got=%b exp=010", {l4, e4, g4}); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid;
        bit seen_done;
        int lat;
        seen_done = 1'b0;
        launch(1'b0, 8'hC0, 8'h40, 1'b0);
        wait_done(1'b0, 12, lat);
        checks++; if (g1 !== 1'b1) begin errors++; $display("FAIL rstmid_pre_g got=%b exp=1", g1); end
        launch(1'b0, 8'h00, 8'h01, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checks++; if ({busy1, done1} !== 2'b00) begin errors++; $display("FAIL rstmid_busy_done got=%b exp=00", {busy1, done1}); end
        checks++; if ({l1, e1, g1} !== 3'b010) begin errors++; $display("FAIL rstmid_flags got=%b exp=010", {l1, e1, g1}); end
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done1 === 1'b1 || busy1 === 1'b1) seen_done = 1'b1;
        end
        checks++; if (seen_done !== 1'b0) begin errors++; $display("FAIL rstmid_no_done got=%b exp=0", seen_done); end
    endtask

    task automatic test_back_to_back;
        int lat;
        launch(1'b0, 8'h80, 8'h7F, 1'b0);
        wait_done(1'b0, 12, lat);
        checks++; if (lat != 1) begin errors++; $display("FAIL b2b_first_latency got=%0d exp=1", lat); end
        launch(1'b0, 8'h05, 8'h03, 1'b0);
        checks++; if ({busy1, done1} !== 2'b10) begin errors++; $display("FAIL b2b_accept got=%b exp=10", {busy1, done1}); end
        wait_done(1'b0, 12, lat);
        checks++; if (lat != 6) begin errors++; $display("FAIL b2b_latency got=%0d exp=6", lat); end
        checks++; if ({l1, e1, g1} !== 3'b001) begin errors++; $display("FAIL b2b_flags got=%b exp=001", {l1, e1, g1}); end
        @(posedge clk); #1;
    endtask

    initial begin
        reset = 1'b1;
        start1 = 1'b0; start4 = 1'b0;
        sm1 = 1'b0; sm4 = 1'b0;
        x1 = '0; y1 = '0; x4 = '0; y4 = '0;
        @(posedge clk); #1;
        test_reset;
        test_equal;
        test_signed;
        test_ignore_start;
        test_chunk4;
        test_reset_mid;
        test_back_to_back;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
